stereo_frame_sequencer: RTL and testbench

- Sits directly upstream of the stereo 10-bit 2:1 output multiplexer.
- Accepts left/right sample pairs over a valid/ready handshake and buffers one pending frame.
- Presents the active pair on the mux data inputs (a = left, b = right) and drives the mux select.
- Alternates select between left and right in fixed-length time slots, giving the downstream DAC/PWM stage a time-multiplexed stereo stream.

---
 rtl/stereo_frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_stereo_frame_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_frame_sequencer.sv
// rtl/stereo_frame_sequencer.sv - stereo frame buffer and left/right slot sequencer feeding a 2:1 output mux
// Optional macro STEREO_SEQ_UNDERRUN_CNT_EN adds a saturating underrun counter with synchronous clear.
module stereo_frame_sequencer #(
  parameter int DATA_W      = 10,
  parameter int SLOT_CYCLES = 256,
  parameter int MIDSCALE    = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic [DATA_W-1:0] mux_a,
  output logic [DATA_W-1:0] mux_b,
  output logic              mux_sel,
  output logic              slot_strobe,
  output logic              busy,
  output logic              underrun
`ifdef STEREO_SEQ_UNDERRUN_CNT_EN
  ,
  input  logic              underrun_clr,
  output logic [7:0]        underrun_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam int                CNT_W    = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [DATA_W-1:0] MID      = DATA_W'(MIDSCALE);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_full_q, pend_full_d;
  logic [DATA_W-1:0] pend_l_q, pend_l_d;
  logic [DATA_W-1:0] pend_r_q, pend_r_d;
  logic [DATA_W-1:0] act_a_q, act_a_d;
  logic [DATA_W-1:0] act_b_q, act_b_d;
  logic              strobe_q, strobe_d;
  logic              under_q, under_d;

  logic slot_end;
  logic load_now;
  logic accept;

  assign slot_end = (cnt_q == CNT_LAST);
  assign load_now = pend_full_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RIGHT) && slot_end));
  // in_ready depends only on registered state so upstream never sees a loop through in_valid
  assign in_ready = !pend_full_q || load_now;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    act_a_d = act_a_q;
    act_b_d = act_b_q;
    under_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (load_now) begin
          state_d = ST_LEFT;
          act_a_d = pend_l_q;
          act_b_d = pend_r_q;
        end
      end
      ST_LEFT: begin
        if (slot_end) begin
          state_d = ST_RIGHT;
          cnt_d   = '0;
        end
      end
      ST_RIGHT: begin
        if (slot_end) begin
          cnt_d = '0;
          if (pend_full_q) begin
            state_d = ST_LEFT;
            act_a_d = pend_l_q;
            act_b_d = pend_r_q;
          end else begin
            state_d = ST_IDLE;
            act_a_d = MID;
            act_b_d = MID;
            under_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        act_a_d = MID;
        act_b_d = MID;
      end
    endcase
  end

  // A simultaneous accept and load refills the buffer, so pend_full stays set
  always_comb begin
    pend_full_d = pend_full_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_l_d    = in_left;
      pend_r_d    = in_right;
    end else if (load_now) begin
      pend_full_d = 1'b0;
    end
  end

  assign strobe_d = (state_d != ST_IDLE) && (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      act_a_q     <= MID;
      act_b_q     <= MID;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      act_a_q     <= act_a_d;
      act_b_q     <= act_b_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
    end
  end

  assign mux_a       = act_a_q;
  assign mux_b       = act_b_q;
  assign mux_sel     = (state_q == ST_RIGHT);
  assign busy        = (state_q != ST_IDLE);
  assign slot_strobe = strobe_q;
  assign underrun    = under_q;

`ifdef STEREO_SEQ_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr) begin
      ucnt_d = '0;
    end else if (under_q && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// tb/tb_stereo_frame_sequencer.sv - scoreboard bench for stereo_frame_sequencer (SLOT_CYCLES = 4)
module tb_stereo_frame_sequencer;

  localparam int SLOT = 4;
  localparam int MID  = 512;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic       sel;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_left;
  logic [9:0] in_right;
  logic [9:0] mux_a;
  logic [9:0] mux_b;
  logic       mux_sel;
  logic       slot_strobe;
  logic       busy;
  logic       underrun;
`ifdef STEREO_SEQ_UNDERRUN_CNT_EN
  logic       underrun_clr;
  logic [7:0] underrun_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int under_cnt = 0;

  slot_t      slot_q[$];
  slot_t      mon_e;
  bit         have_ref = 0;
  int         gap = 0;
  logic [9:0] cur_a, cur_b;
  logic       cur_sel;

  always #5 clk = ~clk;

  stereo_frame_sequencer #(
    .DATA_W(10),
    .SLOT_CYCLES(SLOT),
    .MIDSCALE(MID)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_left(in_left),
    .in_right(in_right),
    .mux_a(mux_a),
    .mux_b(mux_b),
    .mux_sel(mux_sel),
    .slot_strobe(slot_strobe),
    .busy(busy),
    .underrun(underrun)
`ifdef STEREO_SEQ_UNDERRUN_CNT_EN
    ,
    .underrun_clr(underrun_clr),
    .underrun_count(underrun_count)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop one expected slot per strobe, check slot length and stability
  always @(negedge clk) begin
    if (!rst_n) begin
      have_ref = 0;
      gap = 0;
    end else begin
      gap++;
      if (slot_strobe) begin
        if (slot_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          mon_e = slot_q.pop_front();
          check("slot_a", int'(mux_a), int'(mon_e.a));
          check("slot_b", int'(mux_b), int'(mon_e.b));
          check("slot_sel", int'(mux_sel), int'(mon_e.sel));
        end
        if (have_ref) check("slot_len", gap, SLOT);
        cur_a = mux_a;
        cur_b = mux_b;
        cur_sel = mux_sel;
        have_ref = 1;
        gap = 0;
      end else if (busy && have_ref) begin
        check("hold_a", int'(mux_a), int'(cur_a));
        check("hold_b", int'(mux_b), int'(cur_b));
        check("hold_sel", int'(mux_sel), int'(cur_sel));
      end
      if (underrun) begin
        under_cnt++;
        check("under_a_mid", int'(mux_a), MID);
        check("under_b_mid", int'(mux_b), MID);
        check("under_sel", int'(mux_sel), 0);
        check("under_busy", int'(busy), 0);
        if (have_ref) check("last_slot_len", gap, SLOT);
      end
      if (!busy) have_ref = 0;
    end
  end

  // Entered at a negedge; data is scrambled while back-pressured so a wrong accept is visible
  task automatic send(input logic [9:0] l, input logic [9:0] r, output logic sel_at_acc);
    bit done;
    done = 0;
    sel_at_acc = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      if (in_ready) begin
        in_left = l;
        in_right = r;
        sel_at_acc = mux_sel;
        slot_q.push_back('{l, r, 1'b0});
        slot_q.push_back('{l, r, 1'b1});
        @(posedge clk);
        done = 1;
      end else begin
        in_left = 10'($urandom);
        in_right = 10'($urandom);
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_under(input int target, input string name);
    for (int n = 0; n < 300 && under_cnt < target; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, under_cnt, target);
  endtask

  initial begin
    logic s;
    int   u0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_left = '0;
    in_right = '0;
`ifdef STEREO_SEQ_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_mux_a", int'(mux_a), MID);
    check("rst_mux_b", int'(mux_b), MID);
    check("rst_sel", int'(mux_sel), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(slot_strobe), 0);
    check("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame
    u0 = under_cnt;
    send(10'd100, 10'd900, s);
    in_valid = 1'b0;
    check("single_idle_after_accept", int'(busy), 0);
    check("single_mid_after_accept", int'(mux_a), MID);
    @(negedge clk);
    check("single_first_strobe", int'(slot_strobe), 1);
    check("single_first_a", int'(mux_a), 100);
    check("single_first_b", int'(mux_b), 900);
    wait_under(u0 + 1, "single_underruns");
    check("single_slots_left", slot_q.size(), 0);

    // Back-to-back with back-pressure on the third frame
    u0 = under_cnt;
    send(10'd1, 10'd2, s);
    send(10'd3, 10'd4, s);
    check("b2b_ready_drop", int'(in_ready), 0);
    send(10'd5, 10'd6, s);
    check("b2b_third_in_right", int'(s), 1);
    in_valid = 1'b0;
    wait_under(u0 + 1, "b2b_underruns");
    check("b2b_slots_left", slot_q.size(), 0);

    // Reset during RIGHT with a frame pending
    u0 = under_cnt;
    send(10'd7, 10'd8, s);
    send(10'd9, 10'd10, s);
    in_valid = 1'b0;
    for (int n = 0; n < 50 && !mux_sel; n++) @(negedge clk);
    check("rst_mid_reached_right", int'(mux_sel), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", int'(mux_a), MID);
    check("async_rst_b", int'(mux_b), MID);
    check("async_rst_sel", int'(mux_sel), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(in_ready), 1);
    slot_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_replay_busy", int'(busy), 0);
    check("rst_no_replay_ready", int'(in_ready), 1);
    check("rst_no_underrun", under_cnt, u0);

`ifdef STEREO_SEQ_UNDERRUN_CNT_EN
    u0 = under_cnt;
    for (int k = 1; k <= 3; k++) begin
      send(10'(k * 11), 10'(k * 13), s);
      in_valid = 1'b0;
      wait_under(u0 + k, "cnt_underruns");
    end
    check("cnt_three", int'(underrun_count), 3);
    send(10'd44, 10'd55, s);
    in_valid = 1'b0;
    for (int n = 0; n < 50 && !underrun; n++) @(negedge clk);
    check("cnt_fourth_seen", int'(underrun), 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("cnt_clr_priority", int'(underrun_count), 0);
    repeat (2) @(negedge clk);
    check("cnt_clr_hold", int'(underrun_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
